// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block, streams W0..W63 through a 16-word window.
// Optional `SHA256_MSG_SCHED_ABORT_EN adds an abort input that drops the current block.
module sha256_msg_sched #(
    parameter int NROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_round,
`ifdef SHA256_MSG_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         w_last
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] win_q [16];
    logic [31:0] win_d [16];
    logic [31:0] blk_w [16];
    logic [31:0] new_word;
    logic        abort_now;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SHA256_MSG_SCHED_ABORT_EN
    assign abort_now = abort && (state_q == RUN);
`else
    assign abort_now = 1'b0;
`endif

    // Block word 0 is the most significant 32 bits.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            blk_w[i] = blk_data[511 - 32*i -: 32];
        end
    end

    assign new_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_d     = win_q;
        blk_ready = 1'b0;
        w_valid   = 1'b0;
        w_data    = '0;
        w_round   = '0;
        w_last    = 1'b0;

        case (state_q)
            IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    win_d   = blk_w;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                w_valid   = 1'b1;
                w_data    = win_q[0];
                w_round   = cnt_q;
                w_last    = (cnt_q == 6'd63);
                // Final handshake doubles as the acceptance slot for the next block.
                blk_ready = w_last && w_ready && !abort_now;
                if (abort_now) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (w_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = new_word;
                    if (w_last) begin
                        cnt_d = '0;
                        if (blk_valid) begin
                            win_d   = blk_w;
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (!rst_n) begin
            blk_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) w_last |-> (32'(w_round) == NROUNDS - 1));

endmodule
